// File: rtl/ysyx_25050148_mem_pkg.sv
// Shared types and helpers for the IFU/LSU memory arbiter.
// Holds the arbiter state and owner encodings, access size codes and the alignment check.
package ysyx_25050148_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Size code 3 has no legal encoding and is reported as misaligned.
    function automatic logic misaligned(input logic [1:0] addr, input logic [1:0] size);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr[0];
            SZ_W:    bad = (addr != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_25050148_load_fmt.sv
// Combinational load formatter: moves the addressed lane down to bit 0,
// truncates it to the access size and sign- or zero-extends the result.
module ysyx_25050148_load_fmt
    import ysyx_25050148_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] data
);

    logic [31:0] shifted_s;

    // Lane shift followed by size truncation and extension
    always_comb begin
        shifted_s = rdata >> {addr_lo, 3'b000};
        case (size)
            SZ_B:    data = {{24{is_signed & shifted_s[7]}}, shifted_s[7:0]};
            SZ_H:    data = {{16{is_signed & shifted_s[15]}}, shifted_s[15:0]};
            SZ_W:    data = shifted_s;
            default: data = 32'd0;
        endcase
    end

endmodule

// File: rtl/ysyx_25050148_mem_arbiter.sv
// Arbitrates the single memory port between IFU and LSU: one outstanding
// transaction, LSU priority with a starvation guard, registered response pulses.
module ysyx_25050148_mem_arbiter
    import ysyx_25050148_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [3:0]        lsu_wmask,
    input  logic [1:0]        lsu_size,
    input  logic              lsu_signed,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    owner_e            owner_r;
    logic [2:0]        starve_cnt_r;
    logic              wen_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [3:0]        wmask_r;
    logic [1:0]        size_r;
    logic              signed_r;
    logic              mem_req_valid_r;

    logic              starve_full_s;
    logic              lsu_win_s;
    logic              lsu_acc_s;
    logic              ifu_acc_s;
    logic              lsu_mis_s;
    logic              resp_done_s;
    logic [DATA_W-1:0] fmt_data_s;

    // Arbitration: LSU wins unless the starvation guard hands the slot to a waiting IFU
    always_comb begin
        starve_full_s = (starve_cnt_r == STARVE_LIM);
        lsu_win_s     = lsu_req_valid & ~(starve_full_s & ifu_req_valid);
        lsu_mis_s     = misaligned(lsu_addr[1:0], lsu_size);
        resp_done_s   = (state_r == WAIT) & mem_resp_valid;
        if (state_r == IDLE) begin
            lsu_acc_s = lsu_win_s;
            ifu_acc_s = ifu_req_valid & ~lsu_win_s;
        end else begin
            lsu_acc_s = 1'b0;
            ifu_acc_s = 1'b0;
        end
    end

    assign lsu_req_ready = lsu_acc_s;
    assign ifu_req_ready = ifu_acc_s;

    // Next-state logic; a misaligned LSU access is answered locally and never leaves IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (lsu_acc_s) begin
                    state_nxt_s = lsu_mis_s ? IDLE : ISSUE;
                end else if (ifu_acc_s) begin
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register and registered memory request valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            mem_req_valid_r <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            mem_req_valid_r <= (state_nxt_s == ISSUE);
        end
    end

    // Latch the accepted request; these registers drive the memory port directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r  <= OWN_IFU;
            wen_r    <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            wmask_r  <= 4'd0;
            size_r   <= SZ_B;
            signed_r <= 1'b0;
        end else if (ifu_acc_s) begin
            owner_r  <= OWN_IFU;
            wen_r    <= 1'b0;
            addr_r   <= ifu_addr;
            wdata_r  <= '0;
            wmask_r  <= 4'd0;
            size_r   <= SZ_W;
            signed_r <= 1'b0;
        end else if (lsu_acc_s && !lsu_mis_s) begin
            owner_r  <= OWN_LSU;
            wen_r    <= lsu_wen;
            addr_r   <= lsu_addr;
            wdata_r  <= lsu_wdata;
            wmask_r  <= lsu_wmask;
            size_r   <= lsu_size;
            signed_r <= lsu_signed;
        end else begin
            owner_r  <= owner_r;
            wen_r    <= wen_r;
            addr_r   <= addr_r;
            wdata_r  <= wdata_r;
            wmask_r  <= wmask_r;
            size_r   <= size_r;
            signed_r <= signed_r;
        end
    end

    assign mem_req_valid = mem_req_valid_r;
    assign mem_wen       = wen_r;
    assign mem_addr      = addr_r;
    assign mem_wdata     = wdata_r;
    assign mem_wmask     = wmask_r;

    ysyx_25050148_load_fmt u_load_fmt (
        .rdata     (mem_rdata),
        .addr_lo   (addr_r[1:0]),
        .size      (size_r),
        .is_signed (signed_r),
        .data      (fmt_data_s)
    );

    // One-cycle response pulses; data registers keep their last value between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifu_resp_valid <= 1'b0;
            ifu_rdata      <= '0;
            lsu_resp_valid <= 1'b0;
            lsu_rdata      <= '0;
            lsu_err        <= 1'b0;
        end else begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            lsu_err        <= 1'b0;
            if (resp_done_s && owner_r == OWN_LSU) begin
                lsu_resp_valid <= 1'b1;
                lsu_rdata      <= wen_r ? '0 : fmt_data_s;
            end else if (resp_done_s) begin
                ifu_resp_valid <= 1'b1;
                ifu_rdata      <= mem_rdata;
            end else if (lsu_acc_s && lsu_mis_s) begin
                lsu_resp_valid <= 1'b1;
                lsu_err        <= 1'b1;
                lsu_rdata      <= '0;
            end else begin
                ifu_rdata <= ifu_rdata;
                lsu_rdata <= lsu_rdata;
            end
        end
    end

    // Starvation counter: counts LSU wins over a waiting IFU, saturating at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= 3'd0;
        end else if (ifu_acc_s) begin
            starve_cnt_r <= 3'd0;
        end else if (lsu_acc_s && ifu_req_valid && !starve_full_s) begin
            starve_cnt_r <= starve_cnt_r + 3'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

endmodule

// File: tb/tb_ysyx_25050148_mem_arbiter.sv
// Self-checking bench for ysyx_25050148_mem_arbiter: directed scenarios plus
// randomized transactions checked against an arithmetic reference model.
module tb_ysyx_25050148_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_signed;
    logic        lsu_resp_valid, lsu_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic [1:0]  lsu_size;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int total = 0;
    int bad   = 0;
    int starve = 0;

    always #5 clk = ~clk;

    ysyx_25050148_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_size(lsu_size),
        .lsu_signed(lsu_signed), .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .lsu_err(lsu_err), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit ref_mis(input logic [31:0] a, input logic [1:0] size);
        return (size == 2'd3) || (size == 2'd1 && (a % 2) != 0) || (size == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [31:0] a,
                                             input logic [1:0] size, input bit sgn);
        logic [31:0] sh, v;
        sh = d >> (8 * (a % 4));
        if (size == 2'd0) begin
            v = sh % 256;
            if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = sh % 65536;
            if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = sh;
        end
        return v;
    endfunction

    // One full arbitration round; the reference decides the winner and the expected response.
    task automatic xact(input bit iv, input bit lv, input logic wen, input logic [31:0] iaddr,
                        input logic [31:0] laddr, input logic [31:0] wdata, input logic [3:0] wmask,
                        input logic [1:0] size, input bit sgn, input logic [31:0] mdata,
                        input int rdly, input int sdly);
        bit lsu_w, mis;
        logic [31:0] exp_addr, exp_data;
        lsu_w = lv && !(starve == 4 && iv);
        mis   = lsu_w && ref_mis(laddr, size);
        ifu_req_valid = iv;  ifu_addr = iaddr;
        lsu_req_valid = lv;  lsu_wen = wen;  lsu_addr = laddr;  lsu_wdata = wdata;
        lsu_wmask = wmask;   lsu_size = size; lsu_signed = sgn;
        #1;
        chk("lsu_ready", 32'(lsu_req_ready), 32'(lsu_w));
        chk("ifu_ready", 32'(ifu_req_ready), 32'(iv && !lsu_w));
        if (lsu_w && iv) starve = (starve < 4) ? starve + 1 : 4;
        else if (!lsu_w) starve = 0;
        tick();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        if (mis) begin
            chk("mis_resp_valid", 32'(lsu_resp_valid), 32'd1);
            chk("mis_err", 32'(lsu_err), 32'd1);
            chk("mis_rdata", lsu_rdata, 32'd0);
            chk("mis_no_mem", 32'(mem_req_valid), 32'd0);
            tick();
            chk("mis_pulse_end", 32'(lsu_resp_valid), 32'd0);
            chk("mis_still_no_mem", 32'(mem_req_valid), 32'd0);
            return;
        end
        exp_addr = lsu_w ? laddr : iaddr;
        chk("issue_valid", 32'(mem_req_valid), 32'd1);
        chk("issue_addr", mem_addr, exp_addr);
        chk("issue_wen", 32'(mem_wen), 32'(lsu_w && wen));
        if (lsu_w) begin
            chk("issue_wdata", mem_wdata, wdata);
            chk("issue_wmask", 32'(mem_wmask), 32'(wmask));
        end
        chk("no_stale_resp", 32'(ifu_resp_valid | lsu_resp_valid), 32'd0);
        for (int i = 0; i < rdly; i++) begin
            ifu_req_valid = 1'b1;
            lsu_req_valid = 1'b1;
            tick();
            chk("stall_valid", 32'(mem_req_valid), 32'd1);
            chk("stall_addr", mem_addr, exp_addr);
            if (lsu_w) begin
                chk("stall_wdata", mem_wdata, wdata);
                chk("stall_wmask", 32'(mem_wmask), 32'(wmask));
            end
            chk("stall_readies", 32'(ifu_req_ready | lsu_req_ready), 32'd0);
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("wait_no_req", 32'(mem_req_valid), 32'd0);
        for (int i = 0; i < sdly; i++) begin
            tick();
            chk("wait_no_resp", 32'(ifu_resp_valid | lsu_resp_valid), 32'd0);
        end
        mem_resp_valid = 1'b1;
        mem_rdata = mdata;
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata = $urandom;
        if (lsu_w) begin
            exp_data = wen ? 32'd0 : ref_load(mdata, laddr, size, sgn);
            chk("lsu_resp_valid", 32'(lsu_resp_valid), 32'd1);
            chk("lsu_rdata", lsu_rdata, exp_data);
            chk("lsu_err", 32'(lsu_err), 32'd0);
            chk("ifu_quiet", 32'(ifu_resp_valid), 32'd0);
        end else begin
            chk("ifu_resp_valid", 32'(ifu_resp_valid), 32'd1);
            chk("ifu_rdata", ifu_rdata, mdata);
            chk("lsu_quiet", 32'(lsu_resp_valid), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        rst_n = 1'b0;
        ifu_req_valid = 1'b0; ifu_addr = 32'd0;
        lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = 32'd0; lsu_wdata = 32'd0;
        lsu_wmask = 4'd0; lsu_size = 2'd0; lsu_signed = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'd0;
        tick();
        tick();
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_resp", 32'(ifu_resp_valid | lsu_resp_valid | lsu_err), 32'd0);
        chk("rst_rdata", ifu_rdata | lsu_rdata, 32'd0);
        rst_n = 1'b1;
        tick();

        // IFU-only fetch with minimum latency
        xact(1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'd0, 32'd0, 4'd0, 2'd2, 1'b0, 32'h0010_0093, 0, 0);

        // Both requesters valid: four LSU grants, then IFU is forced, then LSU again
        for (int i = 0; i < 6; i++) begin
            xact(1'b1, 1'b1, 1'b0, 32'h8000_0100 + 32'(4 * i), 32'h8000_2000 + 32'(4 * i),
                 32'd0, 4'd0, 2'd2, 1'b0, 32'hA5A5_0000 + 32'(i), 0, 0);
        end

        // Byte/half formatting
        xact(1'b0, 1'b1, 1'b0, 32'd0, 32'h8000_0003, 32'd0, 4'd0, 2'd0, 1'b1, 32'h80FF_1234, 0, 1);
        chk("lb_const", lsu_rdata, 32'hFFFF_FF80);
        xact(1'b0, 1'b1, 1'b0, 32'd0, 32'h8000_0003, 32'd0, 4'd0, 2'd0, 1'b0, 32'h80FF_1234, 0, 0);
        chk("lbu_const", lsu_rdata, 32'h0000_0080);
        xact(1'b0, 1'b1, 1'b0, 32'd0, 32'h8000_0002, 32'd0, 4'd0, 2'd1, 1'b1, 32'h80FF_1234, 1, 0);
        chk("lh_const", lsu_rdata, 32'hFFFF_80FF);

        // Misaligned word load, then a store held off by memory for three cycles
        xact(1'b0, 1'b1, 1'b0, 32'd0, 32'h8000_0002, 32'd0, 4'd0, 2'd2, 1'b0, 32'd0, 0, 0);
        xact(1'b0, 1'b1, 1'b1, 32'd0, 32'h8000_0040, 32'h0000_BEEF, 4'b0011, 2'd1, 1'b0,
             32'h1234_5678, 3, 0);

        // Stray memory response in IDLE must be ignored
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        tick();
        chk("stray_ignored", 32'(ifu_resp_valid | lsu_resp_valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            bit iv, lv;
            iv = 1'($urandom_range(0, 1));
            lv = 1'($urandom_range(0, 1));
            if (!iv && !lv) lv = 1'b1;
            ra = $urandom;
            rb = $urandom;
            xact(iv, lv, 1'($urandom_range(0, 1)), ra & 32'hFFFF_FFFC, rb, $urandom,
                 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset dropped while waiting for memory; the late response must vanish
        ifu_req_valid = 1'b1;
        ifu_addr = 32'h8000_0800;
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_wait_req", 32'(mem_req_valid), 32'd0);
        chk("rst_wait_resp", 32'(ifu_resp_valid | lsu_resp_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        starve = 0;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_resp_valid = 1'b0;
        chk("late_resp_dropped", 32'(ifu_resp_valid | lsu_resp_valid), 32'd0);
        tick();
        chk("late_resp_dropped2", 32'(ifu_resp_valid | lsu_resp_valid), 32'd0);
        xact(1'b1, 1'b1, 1'b0, 32'h8000_0900, 32'h8000_0A01, 32'd0, 4'd0, 2'd0, 1'b1,
             32'h0000_7F00, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_25050148_mem_arbiter.md
# ysyx_25050148_mem_arbiter

Shares the single DPI-backed memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) of the multi-cycle core. It accepts one request at a time over valid/ready handshakes and forwards it to the memory port. It waits for the memory response, formats load data (lane select, byte/half/word, sign/zero extension) and returns it to the owning requester. LSU has fixed priority, bounded by a starvation guard that guarantees IFU progress.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (fixed at 32; wmask is 4 bits)
- `STARVE_MAX`, 4, consecutive LSU grants while IFU waits before IFU is forced
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `ifu_req_valid`  in  1  / `ifu_req_ready`  out  1  IFU request handshake
- `ifu_addr`  in  ADDR_W  fetch address (word-aligned by contract)
- `ifu_resp_valid`  out  1  / `ifu_rdata`  out  DATA_W  one-cycle response pulse, raw word
- `lsu_req_valid`  in  1  / `lsu_req_ready`  out  1  LSU request handshake
- `lsu_wen`  in  1  1 = store
- `lsu_addr`  in  ADDR_W  byte address
- `lsu_wdata`  in  DATA_W  / `lsu_wmask`  in  4  store data and byte mask, already lane-aligned
- `lsu_size`  in  2  0 = byte, 1 = half, 2 = word (3 illegal, treated as misaligned)
- `lsu_signed`  in  1  1 = sign-extend load
- `lsu_resp_valid`  out  1  / `lsu_rdata`  out  DATA_W  / `lsu_err`  out  1  one-cycle response, formatted data, misalign flag
- `mem_req_valid`  out  1  / `mem_req_ready`  in  1  memory request handshake
- `mem_wen`  out  1, `mem_addr`  out  ADDR_W, `mem_wdata`  out  DATA_W, `mem_wmask`  out  4
- `mem_resp_valid`  in  1  / `mem_rdata`  in  DATA_W  memory response (read data or store ack)

## Operation
- **States:** IDLE, ISSUE, WAIT. There is one outstanding transaction, and the owner is recorded in a register.
- **IDLE:**
  - Winner ready is asserted combinationally when its valid is high, and that cycle is acceptance.
  - Winner is LSU if `lsu_req_valid`, unless `starve_cnt==STARVE_MAX` and `ifu_req_valid`. Otherwise IFU.
  - On acceptance, all request fields are latched and the state goes to ISSUE.
  - Both readies are 0 in ISSUE and WAIT.
- **Misaligned LSU access:**
  - Half with `addr[0]` set, word with `addr[1:0]!=0`, or size 3.
  - The request is accepted, the memory is never driven, and the state stays in IDLE.
  - Next cycle: `lsu_resp_valid=1`, `lsu_err=1`, `lsu_rdata=0`.
- **ISSUE:** `mem_req_valid=1` with the latched fields held stable until `mem_req_ready`, then WAIT.
- **WAIT:** on `mem_resp_valid`, go to IDLE. The registered response goes to the owner next cycle.
- **Response formatting:**
  - IFU gets `mem_rdata` raw.
  - LSU load: `mem_rdata >> (addr[1:0]*8)`, truncate to size, then sign-extend (`lsu_signed`) or zero-extend.
  - LSU store: `lsu_rdata=0`.
- **Stray responses:** `mem_resp_valid` outside WAIT is ignored.
- **Starvation counter (`starve_cnt`, 3 bits, saturating at STARVE_MAX):**
  - +1 on an LSU grant while `ifu_req_valid` is high.
  - Cleared on an IFU grant.
  - Unchanged otherwise.

## Timing
- **Reset values:** all outputs 0, state IDLE, `starve_cnt` 0. Reset mid-transaction abandons it, and no response is emitted.
- **Minimum latency:** accept at t0, `mem_req_valid` at t1, `mem_resp_valid` earliest at t2, `*_resp_valid` at t3.
- **Misaligned path:** response at t1.
- **Back-to-back:** a new request may be accepted in the same cycle a response pulse is output (IDLE).
- **Response pulses:** exactly 1 cycle, with no backpressure. Requesters must always sink them.
- **Memory wait:** `mem_req_ready` low holds ISSUE indefinitely. Fields and `mem_req_valid` stay stable.

## Structure
- **Package `ysyx_25050148_mem_pkg`:**
  - state enum {IDLE, ISSUE, WAIT}
  - owner enum {OWN_IFU, OWN_LSU}
  - size constants SZ_B=0, SZ_H=1, SZ_W=2
  - function `misaligned(addr, size)`
- **Sub-module `ysyx_25050148_load_fmt`:** purely combinational lane shift and extension, reused by the LSU.

## Test plan
- **IFU-only fetch:** `ifu_addr=0x8000_0000`, memory returns `0x0010_0093` one cycle after handshake -> `ifu_resp_valid` at t3 with `ifu_rdata=0x0010_0093`.
- **Both valid at once from reset:** LSU granted first. With LSU valid continuously, IFU is granted on the 5th arbitration (after 4 LSU grants), then the counter is 0 again.
- **lb vs lbu at `addr=0x...3`:** `mem_rdata=0x80FF_1234`. lb -> `0xFFFF_FF80`; lbu -> `0x0000_0080`; lh at `0x...2` -> `0xFFFF_80FF`.
- **Misaligned lw at `0x...2`:** `mem_req_valid` never asserts. Next cycle `lsu_resp_valid=1`, `lsu_err=1`, `lsu_rdata=0`.
- **Store with `mem_req_ready` low for 3 cycles:** `mem_addr`, `mem_wdata`, `mem_wmask=4'b0011` stay stable. Ack -> `lsu_resp_valid`, `lsu_rdata=0`.
- **`rst_n` dropped in WAIT, memory response arrives after release:** no `*_resp_valid` is emitted, and the state is IDLE.
